// File: rtl/shl_pkg.sv
// Shared types and constants for the sequential left shifter/rotator.
package shl_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shl_state_t;

    localparam logic OP_SLL = 1'b0;
    localparam logic OP_ROL = 1'b1;

endpackage

// File: rtl/multiplexer_2to1.sv
// Generic two-input multiplexer cell: y = sel ? b : a.
module multiplexer_2to1 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/shift_left_stage.sv
// One conditional left shift/rotate by 2^Sel, built from 2:1 mux cells.
module shift_left_stage
    import shl_pkg::*;
(
    input  logic [WIDTH-1:0] In,
    input  logic             Cnt,
    input  logic             Op,
    input  logic [SEL_W-1:0] Sel,
    output logic [WIDTH-1:0] Out
);

    logic [STAGES-1:0][WIDTH-1:0] cand;
    logic [WIDTH-1:0]             amt_lo;
    logic [WIDTH-1:0]             amt_hi;
    logic [WIDTH-1:0]             shifted;
    logic                         is_rol;

    assign is_rol = (Op == OP_ROL);

    // Candidate result for each barrel amount, fill chosen by the op.
    for (genvar j = 0; j < STAGES; j++) begin : g_amt
        localparam int unsigned AMT = 1 << j;
        logic [WIDTH-1:0] sll_v;
        logic [WIDTH-1:0] rol_v;

        assign sll_v = In << AMT;
        assign rol_v = (In << AMT) | (In >> (WIDTH - AMT));

        multiplexer_2to1 #(.WIDTH(WIDTH)) u_op (
            .a   (sll_v),
            .b   (rol_v),
            .sel (is_rol),
            .y   (cand[j])
        );
    end

    multiplexer_2to1 #(.WIDTH(WIDTH)) u_sel_lo (
        .a   (cand[0]),
        .b   (cand[1]),
        .sel (Sel[0]),
        .y   (amt_lo)
    );

    multiplexer_2to1 #(.WIDTH(WIDTH)) u_sel_hi (
        .a   (cand[2]),
        .b   (cand[3]),
        .sel (Sel[0]),
        .y   (amt_hi)
    );

    multiplexer_2to1 #(.WIDTH(WIDTH)) u_sel (
        .a   (amt_lo),
        .b   (amt_hi),
        .sel (Sel[1]),
        .y   (shifted)
    );

    multiplexer_2to1 #(.WIDTH(WIDTH)) u_en (
        .a   (In),
        .b   (shifted),
        .sel (Cnt),
        .y   (Out)
    );

endmodule

// File: rtl/shift_left_sequential.sv
// Multi-cycle 16-bit left shifter/rotator, one barrel stage per clock.
// Define SHL_EARLY_DONE_EN to finish as soon as no higher count bits remain.
module shift_left_sequential
    import shl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] In,
    input  logic [3:0]       Cnt,
    input  logic             Op,
    output logic [WIDTH-1:0] Out,
    output logic             busy,
    output logic             done
);

    shl_state_t       state, state_nxt;
    logic [SEL_W-1:0] k, k_nxt;
    logic [WIDTH-1:0] work, work_nxt;
    logic [3:0]       cnt_q, cnt_nxt;
    logic             op_q, op_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [WIDTH-1:0] stage_out;
    logic             last_stage;

    shift_left_stage u_stage (
        .In  (work),
        .Cnt (cnt_q[k]),
        .Op  (op_q),
        .Sel (k),
        .Out (stage_out)
    );

`ifdef SHL_EARLY_DONE_EN
    logic [3:0] cnt_rem;
    // Remaining count bits above the current stage; none left means finished.
    assign cnt_rem    = cnt_q >> (3'(k) + 3'd1);
    assign last_stage = (k == SEL_W'(STAGES - 1)) || (cnt_rem == 4'd0);
`else
    assign last_stage = (k == SEL_W'(STAGES - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            work  <= '0;
            cnt_q <= '0;
            op_q  <= OP_SLL;
            Out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            work  <= work_nxt;
            cnt_q <= cnt_nxt;
            op_q  <= op_nxt;
            Out   <= out_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        work_nxt  = work;
        cnt_nxt   = cnt_q;
        op_nxt    = op_q;
        out_nxt   = Out;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    work_nxt  = In;
                    cnt_nxt   = Cnt;
                    op_nxt    = Op;
                    k_nxt     = '0;
                    state_nxt = SHIFT;
                    busy_nxt  = 1'b1;
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                work_nxt = stage_out;
                if (last_stage) begin
                    out_nxt   = stage_out;
                    k_nxt     = '0;
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    k_nxt    = k + SEL_W'(1);
                    busy_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_left_sequential.sv
// Self-checking bench for shift_left_sequential: vector table, corner sequences, random ops.
module tb_shift_left_sequential;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] In;
    logic [3:0]  Cnt;
    logic        Op;
    logic [15:0] Out;
    logic        busy;
    logic        done;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] prev_out;

    typedef struct {
        logic [15:0] x;
        logic [3:0]  c;
        logic        op;
        logic [15:0] exp;
    } vec_t;

    shift_left_sequential dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .In    (In),
        .Cnt   (Cnt),
        .Op    (Op),
        .Out   (Out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got busy=%0b done=%0b Out=%h, expected busy=%0b done=%0b Out=%h",
                     name, got[17], got[16], got[15:0], exp[17], exp[16], exp[15:0]);
        end
    endtask

    // Reference: plain arithmetic shift / rotate on a wide integer.
    function automatic logic [15:0] ref_model(input logic [15:0] x, input int c, input logic op);
        int v;
        int s;
        v = int'(x);
        s = c % 16;
        if (op) return 16'(((v << s) | (v >> (16 - s))) & 32'hFFFF);
        return 16'((v << s) & 32'hFFFF);
    endfunction

    function automatic int latency(input int c);
`ifdef SHL_EARLY_DONE_EN
        if (c < 2) return 2;
        if (c < 4) return 3;
        if (c < 8) return 4;
        return 5;
`else
        return 5 + 0 * c;
`endif
    endfunction

    // Starts an op in the current cycle and returns positioned in its done cycle.
    task automatic run_op(input logic [15:0] x, input logic [3:0] c, input logic op,
                          input logic [15:0] exp, input int noise_j, input string name);
        int l;
        l = latency(int'(c));
        start = 1'b1;
        In    = x;
        Cnt   = c;
        Op    = op;
        step();
        for (int j = 1; j <= l; j++) begin
            if (j == noise_j) begin
                start = 1'b1;
                In    = 16'hFFFF;
                Cnt   = 4'hF;
                Op    = 1'b1;
            end else begin
                start = 1'b0;
                In    = 16'($urandom);
                Cnt   = 4'($urandom);
                Op    = 1'($urandom);
            end
            check(name, {busy, done, Out},
                  (j == l) ? {1'b0, 1'b1, exp} : {1'b1, 1'b0, prev_out});
            if (j < l) step();
        end
        prev_out = exp;
    endtask

    task automatic idle_check(input string name);
        start = 1'b0;
        step();
        check(name, {busy, done, Out}, {2'b00, prev_out});
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{16'h0001, 4'd15, 1'b0, 16'h8000};
        vecs[1] = '{16'h8001, 4'd1,  1'b1, 16'h0003};
        vecs[2] = '{16'h1234, 4'd4,  1'b1, 16'h2341};
        vecs[3] = '{16'h1234, 4'd4,  1'b0, 16'h2340};
        vecs[4] = '{16'hBEEF, 4'd0,  1'b0, 16'hBEEF};
        vecs[5] = '{16'hBEEF, 4'd0,  1'b1, 16'hBEEF};
        vecs[6] = '{16'h00FF, 4'd8,  1'b0, 16'hFF00};
        vecs[7] = '{16'hF00F, 4'd12, 1'b1, 16'hFF00};
        vecs[8] = '{16'h8421, 4'd3,  1'b1, 16'h210C};
        vecs[9] = '{16'hFFFF, 4'd15, 1'b0, 16'h8000};

        rst      = 1'b1;
        start    = 1'b0;
        In       = '0;
        Cnt      = '0;
        Op       = 1'b0;
        prev_out = 16'h0000;
        step();
        step();
        check("reset", {busy, done, Out}, 18'h0);
        rst = 1'b0;
        idle_check("idle_after_reset");

        foreach (vecs[i]) begin
            run_op(vecs[i].x, vecs[i].c, vecs[i].op, vecs[i].exp, 0, $sformatf("vec%0d", i));
            idle_check($sformatf("vec%0d_after", i));
        end

        // Request during SHIFT is dropped, then a request in the done cycle is taken.
        run_op(16'h00F0, 4'd4, 1'b0, 16'h0F00, 2, "ignore_busy_start");
        run_op(16'h00FF, 4'd8, 1'b0, 16'hFF00, 0, "back_to_back");
        idle_check("back_to_back_after");

        // Reset in T+2 abandons the operation.
        start = 1'b1;
        In    = 16'h1234;
        Cnt   = 4'd15;
        Op    = 1'b0;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        prev_out = 16'h0000;
        check("reset_abort", {busy, done, Out}, 18'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("reset_no_done", {busy, done, Out}, 18'h0);
        end
        run_op(16'h0003, 4'd2, 1'b1, 16'h000C, 0, "after_reset");
        idle_check("after_reset_idle");

        for (int i = 0; i < 1200; i++) begin
            logic [15:0] x;
            logic [3:0]  c;
            logic        op;
            x  = 16'($urandom);
            c  = 4'($urandom_range(0, 15));
            op = 1'($urandom);
            run_op(x, c, op, ref_model(x, int'(c), op), 0, "rand");
            if ($urandom_range(0, 1) == 1) idle_check("rand_idle");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
